ntt_ctrl: RTL and testbench
===========================

Name: ntt_ctrl

Overview:
- Sequencing controller for one 12-bit Kyber butterfly unit and a dual-port 256-coefficient RAM.
- Runs a full 7-layer forward NTT (CT butterflies) or inverse NTT (GS butterflies) in place.
- Each cycle it issues coefficient read addresses, a twiddle ROM address and the CT/GS select, and delays write-back addresses to match pipeline latency.
- Sits between the top-level polynomial-multiplier FSM (start/done) and the butterfly/RAM/ROM datapath.

Parameters:
- RD_LAT, 1, cycles from rd_en to data valid at butterfly A/B/W inputs.
- BF_LAT, 4, butterfly latency from A/B/W inputs to E/O outputs.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high. The only clock is clk.
- start  in  1  request a transform; sampled only in IDLE.
- mode  in  1  0 = NTT (CT), 1 = INTT (GS); sampled with start.
- hold  in  1  pause issuing new butterflies.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the last write-back completes.
- bf_ct  out  1  butterfly CT select; equals the latched mode inverted.
- rd_en  out  1  read issue strobe.
- rd_addr_a  out  8  even-side coefficient address.
- rd_addr_b  out  8  odd-side coefficient address.
- tw_addr  out  7  twiddle ROM index.
- wr_en  out  1  write-back strobe (E to port A, O to port B).
- wr_addr_a  out  8  write address for E.
- wr_addr_b  out  8  write address for O.

Behaviour:
- Reset: all outputs 0, state IDLE, delay line cleared. rst mid-transform aborts immediately; no done pulse.
- Latency constant: D = RD_LAT + BF_LAT.
- States:
  - IDLE: start=1 latches mode, goes to RUN. A start while busy is ignored.
  - RUN: one butterfly issued per cycle when hold=0, with rd_en=1.
  - DRAIN: lasts exactly D cycles, no issue. Afterwards go to RUN for the next layer, or DONE after layer 6.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- Layers:
  - NTT: len = 128, 64, …, 2.
  - INTT: len = 2, 4, …, 128.
  - Every layer is 128 butterflies, taken in groups of len.
- Addressing:
  - Butterfly j of group g: rd_addr_a = g·2·len + j, rd_addr_b = rd_addr_a + len.
  - NTT twiddle: k starts at 1 and increments per group across layers (1; 2–3; …; 64–127).
  - INTT twiddle: k starts at 127 and decrements per group (127…64; …; 1).
  - tw_addr = k.
- bf_ct is constant for the whole transform and changes only on start acceptance.
- Write-back:
  - A shift line of depth D carries {valid, addr_a, addr_b}.
  - wr_en and wr_addr_* equal the entry issued D cycles earlier.
- hold:
  - RUN with hold=1: rd_en=0, and addresses, k and counters freeze.
  - The delay line keeps shifting, inserting bubbles.
  - hold is ignored in DRAIN/DONE/IDLE.
- Hazard rule: the first read of layer L+1 occurs no earlier than the cycle after the last write of layer L (guaranteed by DRAIN).
- Timing: with no holds, start accepted at cycle 0 gives the first rd_en at cycle 1 and done at cycle 7·(128+D)+1 (932 with defaults). Each hold cycle in RUN adds exactly one cycle.
- Invariant: wr_en pulses total exactly 896 per transform.

Optional Feature:
- Macro NTT_CTRL_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort=1 in any non-IDLE state goes to IDLE next cycle.
  - It clears the delay line, forcing wr_en=0 from the next cycle, and drops busy.
  - No done pulse.
  - abort has priority over start and hold; abort in IDLE has no effect.
- Undefined: no port; a transform always runs to completion unless rst is asserted.

Decomposition:
- Shared package kyber_pkg holds:
  - N=256, Q=3329, COEF_W=12, ADDR_W=8, TW_W=7, LAYERS=7.
  - The state enum {IDLE, RUN, DRAIN, DONE}.
- One sub-module, ntt_addr_gen: holds the len/group/j/k counters with step and layer-init inputs.
- Delay line and FSM stay in ntt_ctrl.

Test Plan:
- NTT, no hold, defaults:
  - First rd_en at cycle 1 with a=0, b=128, tw=1.
  - First issue of layer 2 gives a=0, b=64, tw=2.
  - done at cycle 932; 896 wr_en pulses; wr_addr sequence equals rd_addr sequence delayed 5.
- INTT, no hold:
  - First issue a=0, b=2, tw=127, bf_ct=0.
  - Last issue a=127, b=255, tw=1.
  - done at cycle 932.
- hold=1 for 10 cycles mid-layer 3 → done at cycle 942, no address skipped or duplicated, wr_en gaps of 10.
- start reasserted while busy, with mode toggled → ignored; bf_ct and timing unchanged.
- rst at cycle 300 → next cycle all outputs 0, no done; a subsequent start runs a clean 932-cycle transform.
- With NTT_CTRL_ABORT_EN: abort at cycle 500 → busy=0 and wr_en=0 from cycle 501, no done; a restart behaves as the first test.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared constants, FSM state type and twiddle-layer helpers for the Kyber NTT
// datapath and its sequencing controller.
package kyber_pkg;

   localparam int N      = 256;
   localparam int Q      = 3329;
   localparam int COEF_W = 12;
   localparam int ADDR_W = 8;
   localparam int TW_W   = 7;
   localparam int LAYERS = 7;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   // NTT walks len downward from N/2, INTT walks it upward from 2.
   function automatic logic [ADDR_W-1:0] first_len(input logic inv);
      return inv ? ADDR_W'(2) : ADDR_W'(N / 2);
   endfunction

   function automatic logic [ADDR_W-1:0] next_len(input logic [ADDR_W-1:0] len, input logic inv);
      return inv ? (len << 1) : (len >> 1);
   endfunction

endpackage

// File: rtl/ntt_addr_gen.sv
// Butterfly address generator: tracks len, group base, in-group index j and
// twiddle index k; advances one butterfly per step.
module ntt_addr_gen
   import kyber_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              init,
   input  logic              inv,
   input  logic              layer_init,
   input  logic              step,
   output logic [ADDR_W-1:0] rd_addr_a,
   output logic [ADDR_W-1:0] rd_addr_b,
   output logic [TW_W-1:0]   tw_addr,
   output logic              last_bf,
   output logic              last_layer
);

   logic              inv_q;
   logic [2:0]        layer;
   logic [ADDR_W-1:0] len;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] j;
   logic [TW_W-1:0]   k;

   always_ff @(posedge clk) begin
      if (rst) begin
         inv_q <= 1'b0;
         layer <= '0;
         len   <= '0;
         base  <= '0;
         j     <= '0;
         k     <= '0;
      end else if (init) begin
         inv_q <= inv;
         layer <= '0;
         len   <= first_len(inv);
         base  <= '0;
         j     <= '0;
         k     <= inv ? TW_W'(127) : TW_W'(1);
      end else if (layer_init) begin
         layer <= layer + 3'd1;
         len   <= next_len(len, inv_q);
         base  <= '0;
         j     <= '0;
      end else if (step) begin
         // k moves once per group and carries straight across layer boundaries
         if (j == len - ADDR_W'(1)) begin
            j    <= '0;
            base <= base + (len << 1);
            k    <= inv_q ? k - TW_W'(1) : k + TW_W'(1);
         end else begin
            j <= j + ADDR_W'(1);
         end
      end
   end

   always_comb begin
      rd_addr_a  = base + j;
      rd_addr_b  = base + j + len;
      tw_addr    = k;
      last_bf    = (rd_addr_b == ADDR_W'(N - 1));
      last_layer = (layer == 3'(LAYERS - 1));
   end

endmodule

// File: rtl/ntt_ctrl.sv
// Forward/inverse NTT sequencing controller: issues butterfly reads and delays
// write-back addresses by RD_LAT+BF_LAT. Optional abort input: NTT_CTRL_ABORT_EN.
module ntt_ctrl
   import kyber_pkg::*;
#(
   parameter int RD_LAT = 1,
   parameter int BF_LAT = 4
) (
   input  logic              clk,
   input  logic              rst,
`ifdef NTT_CTRL_ABORT_EN
   input  logic              abort,
`endif
   input  logic              start,
   input  logic              mode,
   input  logic              hold,
   output logic              busy,
   output logic              done,
   output logic              bf_ct,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr_a,
   output logic [ADDR_W-1:0] rd_addr_b,
   output logic [TW_W-1:0]   tw_addr,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr_a,
   output logic [ADDR_W-1:0] wr_addr_b
);

   localparam int D  = RD_LAT + BF_LAT;
   localparam int CW = (D > 1) ? $clog2(D) : 1;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] a;
      logic [ADDR_W-1:0] b;
   } wb_t;

   state_t   state, state_n;
   logic [CW-1:0] drain_cnt;
   logic     drain_last;
   logic     abort_act;
   logic     init, layer_init, step;
   logic     last_bf, last_layer;
   wb_t      line [D];

`ifdef NTT_CTRL_ABORT_EN
   assign abort_act = abort && (state != IDLE);
`else
   assign abort_act = 1'b0;
`endif

   assign drain_last = (drain_cnt == CW'(D - 1));

   ntt_addr_gen u_addr_gen (
      .clk        (clk),
      .rst        (rst),
      .init       (init),
      .inv        (mode),
      .layer_init (layer_init),
      .step       (step),
      .rd_addr_a  (rd_addr_a),
      .rd_addr_b  (rd_addr_b),
      .tw_addr    (tw_addr),
      .last_bf    (last_bf),
      .last_layer (last_layer)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = RUN;
         RUN:     if (!hold && last_bf) state_n = DRAIN;
         DRAIN:   if (drain_last) state_n = last_layer ? DONE : RUN;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (abort_act) state_n = IDLE;
   end

   always_comb begin
      rd_en      = (state == RUN) && !hold && !abort_act;
      step       = rd_en;
      init       = (state == IDLE) && start;
      layer_init = (state == DRAIN) && drain_last && !last_layer && !abort_act;
      busy       = (state == RUN) || (state == DRAIN);
      done       = (state == DONE);
      wr_en      = line[D-1].valid;
      wr_addr_a  = line[D-1].a;
      wr_addr_b  = line[D-1].b;
   end

   always_ff @(posedge clk) begin
      if (rst || state != DRAIN) drain_cnt <= '0;
      else                       drain_cnt <= drain_cnt + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)       bf_ct <= 1'b0;
      else if (init) bf_ct <= ~mode;
   end

   // Bubbles (hold, drain) enter the line as all-zero entries.
   always_ff @(posedge clk) begin
      if (rst || abort_act) begin
         for (int unsigned i = 0; i < D; i++) line[i] <= '0;
      end else begin
         line[0] <= '{valid: rd_en,
                      a: rd_en ? rd_addr_a : '0,
                      b: rd_en ? rd_addr_b : '0};
         for (int unsigned i = 1; i < D; i++) line[i] <= line[i-1];
      end
   end

endmodule

// File: tb/tb_ntt_ctrl.sv
// Self-checking bench for ntt_ctrl: table of transform scenarios checked against
// a butterfly-list reference model, plus mid-run reset/abort sequences.
module tb_ntt_ctrl;

   localparam int D   = 5;
   localparam int NBF = 896;

   typedef struct {
      logic m;
      int   hk;
      logic pokes;
      int   exp_done;
      logic ect;
      int   fa, fb, ft;
      int   sa, sb, st;
      int   la, lb, lt;
   } vec_t;

   vec_t tbl[5];

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic mode = 1'b0;
   logic hold = 1'b0;
`ifdef NTT_CTRL_ABORT_EN
   logic abort = 1'b0;
`endif
   logic       busy, done, bf_ct, rd_en, wr_en;
   logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
   logic [6:0] tw_addr;

   int checks = 0;
   int failures = 0;

   int ea[NBF], eb[NBF], ek[NBF];
   int r_done, m_done, wcnt, err_rd, err_wr, err_st, err_ct, r_ct, left_wq;
   int ra[3], rb[3], rt[3];

   ntt_ctrl #(.RD_LAT(1), .BF_LAT(4)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef NTT_CTRL_ABORT_EN
      .abort     (abort),
`endif
      .start     (start),
      .mode      (mode),
      .hold      (hold),
      .busy      (busy),
      .done      (done),
      .bf_ct     (bf_ct),
      .rd_en     (rd_en),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .tw_addr   (tw_addr),
      .wr_en     (wr_en),
      .wr_addr_a (wr_addr_a),
      .wr_addr_b (wr_addr_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference butterfly order, straight from the layer/group/index rules.
   task automatic build(input logic m);
      int n, k, len;
      n = 0;
      k = m ? 127 : 1;
      for (int l = 0; l < 7; l++) begin
         len = m ? (2 << l) : (128 >> l);
         for (int g = 0; g < 128 / len; g++) begin
            for (int j = 0; j < len; j++) begin
               ea[n] = g * 2 * len + j;
               eb[n] = ea[n] + len;
               ek[n] = k;
               n++;
            end
            k = m ? k - 1 : k + 1;
         end
      end
   endtask

   task automatic run_xform(input logic m, input int hk, input logic pokes);
      int idx, gap, c, dexp, slot;
      int wq_c[$], wq_a[$], wq_b[$];
      logic h, xrd, xwr, xdone;
      build(m);
      idx = 0; gap = 0; dexp = -1;
      r_done = -1; wcnt = 0; r_ct = -1;
      err_rd = 0; err_wr = 0; err_st = 0; err_ct = 0;
      for (int i = 0; i < 3; i++) begin ra[i] = -1; rb[i] = -1; rt[i] = -1; end
      @(negedge clk);
      start = 1'b1; mode = m; hold = 1'b0;
      c = 0;
      while (c < 3000) begin
         @(negedge clk);
         c++;
         start = 1'b0;
         mode = ~m;
         if (pokes && (c == 50 || c == 400 || c == 700)) start = 1'b1;
         case (hk)
            1:       h = (c >= 300 && c < 310);
            2:       h = ($urandom_range(0, 3) == 0);
            default: h = 1'b0;
         endcase
         hold = h;
         #1;
         if (c == 1) r_ct = int'(bf_ct);
         if (bf_ct !== ~m) err_ct++;
         xrd = (idx < NBF) && (gap == 0) && !h;
         if (rd_en !== xrd) err_rd++;
         if (xrd) begin
            if (rd_addr_a !== 8'(ea[idx]) || rd_addr_b !== 8'(eb[idx]) || tw_addr !== 7'(ek[idx]))
               err_rd++;
            slot = (idx == 0) ? 0 : (idx == 128) ? 1 : (idx == NBF - 1) ? 2 : -1;
            if (slot >= 0) begin
               ra[slot] = int'(rd_addr_a); rb[slot] = int'(rd_addr_b); rt[slot] = int'(tw_addr);
            end
            wq_c.push_back(c + D); wq_a.push_back(ea[idx]); wq_b.push_back(eb[idx]);
            idx++;
            if (idx % 128 == 0) gap = D;
         end else if (gap > 0) begin
            gap--;
            if (gap == 0 && idx == NBF) dexp = c + 1;
         end
         xwr = (wq_c.size() > 0) && (wq_c[0] == c);
         if (wr_en !== xwr) err_wr++;
         if (xwr) begin
            if (wr_addr_a !== 8'(wq_a[0]) || wr_addr_b !== 8'(wq_b[0])) err_wr++;
            void'(wq_c.pop_front()); void'(wq_a.pop_front()); void'(wq_b.pop_front());
         end
         if (wr_en === 1'b1) wcnt++;
         xdone = (c == dexp);
         if (done !== xdone || busy !== !xdone) err_st++;
         if (done === 1'b1 && r_done < 0) r_done = c;
         if (xdone || done === 1'b1) break;
      end
      m_done = dexp;
      left_wq = wq_c.size();
      @(negedge clk);
      start = 1'b0; hold = 1'b0; mode = 1'b0;
      #1;
      if (busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0 || wr_en !== 1'b0) err_st++;
   endtask

   task automatic apply_entry(input int i);
      run_xform(tbl[i].m, tbl[i].hk, tbl[i].pokes);
      check($sformatf("v%0d_done_cycle", i), r_done, (tbl[i].exp_done > 0) ? tbl[i].exp_done : m_done);
      check($sformatf("v%0d_wr_count", i), wcnt, NBF);
      check($sformatf("v%0d_rd_seq_err", i), err_rd, 0);
      check($sformatf("v%0d_wr_seq_err", i), err_wr, 0);
      check($sformatf("v%0d_busy_done_err", i), err_st, 0);
      check($sformatf("v%0d_bf_ct_hold_err", i), err_ct, 0);
      check($sformatf("v%0d_wb_pending", i), left_wq, 0);
      check($sformatf("v%0d_bf_ct", i), r_ct, int'(tbl[i].ect));
      check($sformatf("v%0d_first_a", i), ra[0], tbl[i].fa);
      check($sformatf("v%0d_first_b", i), rb[0], tbl[i].fb);
      check($sformatf("v%0d_first_tw", i), rt[0], tbl[i].ft);
      check($sformatf("v%0d_l2_a", i), ra[1], tbl[i].sa);
      check($sformatf("v%0d_l2_b", i), rb[1], tbl[i].sb);
      check($sformatf("v%0d_l2_tw", i), rt[1], tbl[i].st);
      check($sformatf("v%0d_last_a", i), ra[2], tbl[i].la);
      check($sformatf("v%0d_last_b", i), rb[2], tbl[i].lb);
      check($sformatf("v%0d_last_tw", i), rt[2], tbl[i].lt);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_rd_en"}, rd_en, 1'b0);
      check({tag, "_wr_en"}, wr_en, 1'b0);
      check({tag, "_done"}, done, 1'b0);
   endtask

   initial begin
      //        m     hk pokes done  ct    first        layer2       last
      tbl[0] = '{1'b0, 0, 1'b0, 932, 1'b1, 0, 128, 1,   0, 64, 2,    253, 255, 127};
      tbl[1] = '{1'b1, 0, 1'b0, 932, 1'b0, 0, 2, 127,   0, 4, 63,    127, 255, 1};
      tbl[2] = '{1'b0, 1, 1'b0, 942, 1'b1, 0, 128, 1,   0, 64, 2,    253, 255, 127};
      tbl[3] = '{1'b1, 0, 1'b1, 932, 1'b0, 0, 2, 127,   0, 4, 63,    127, 255, 1};
      tbl[4] = '{1'b0, 2, 1'b0, 0,   1'b1, 0, 128, 1,   0, 64, 2,    253, 255, 127};

      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_quiet("reset");
      check("reset_bf_ct", bf_ct, 1'b0);
      check("reset_rd_addr", {rd_addr_a, rd_addr_b, tw_addr}, 0);
      check("reset_wr_addr", {wr_addr_a, wr_addr_b}, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) apply_entry(i);

      // Synchronous reset in the middle of layer 3.
      begin
         int ndone;
         ndone = 0;
         @(negedge clk);
         start = 1'b1; mode = 1'b0;
         for (int c = 1; c <= 301; c++) begin
            @(negedge clk);
            start = 1'b0;
            rst = (c == 300);
         end
         #1;
         check_quiet("midrst");
         check("midrst_bf_ct", bf_ct, 1'b0);
         check("midrst_rd_addr", {rd_addr_a, rd_addr_b, tw_addr}, 0);
         check("midrst_wr_addr", {wr_addr_a, wr_addr_b}, 0);
         for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1 || wr_en === 1'b1) ndone++;
         end
         check("midrst_no_done", ndone, 0);
         apply_entry(0);
      end

`ifdef NTT_CTRL_ABORT_EN
      begin
         int nact;
         nact = 0;
         @(negedge clk);
         start = 1'b1; mode = 1'b0;
         for (int c = 1; c <= 501; c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = (c == 500);
         end
         #1;
         check_quiet("abort");
         for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1 || wr_en === 1'b1 || busy === 1'b1) nact++;
         end
         check("abort_stays_idle", nact, 0);
         apply_entry(0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
